// File: rtl/xfer_seq_ctrl.sv
// Burst sequencer: moves a length-programmed run of beats from in_* to out_*
// through a 2-entry registered buffer, applying a per-burst transform.
module xfer_seq_ctrl #(
  parameter int DW = 23,
  parameter int BW = 5,
  parameter int PW = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          kill,
  input  logic          hold,
  input  logic          start,
  input  logic [BW-1:0] len,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] beat_cnt,
  output logic [PW-1:0] phase,
  output logic          busy,
  output logic          done,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] len_q, len_d, beat_cnt_q, beat_cnt_d, beat_inc;
  logic [1:0]    mode_q, mode_d, cnt_q, cnt_d;
  logic [DW-1:0] head_q, head_d, tail_q, tail_d, first_q, first_d, push_data;
  logic [PW-1:0] phase_q, phase_d;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          accept, pop;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    mode_d      = mode_q;
    beat_cnt_d  = beat_cnt_q;
    cnt_d       = cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    first_d     = first_q;
    phase_d     = phase_q;
    err_d       = 1'b0;
    done_d      = 1'b0;
    // in_ready is registered, so a hold raised this cycle must still block the accept
    accept      = (state_q == RUN) && in_valid && in_ready_q && !hold;
    pop         = out_valid_q && out_ready;
    beat_inc    = beat_cnt_q + 1'b1;

    if (mode_q[1])      push_data = (beat_cnt_q == '0) ? in_data : first_q;
    else if (mode_q[0]) push_data = ~in_data;
    else                push_data = in_data;
    if (accept && beat_cnt_q == '0) first_d = in_data;

    case (cnt_q)
      2'd0: if (accept) begin
        head_d = push_data;
        cnt_d  = 2'd1;
      end
      2'd1: begin
        if (accept && pop) head_d = push_data;
        else if (accept) begin
          tail_d = push_data;
          cnt_d  = 2'd2;
        end else if (pop) cnt_d = 2'd0;
      end
      default: if (pop) begin
        head_d = tail_q;
        if (accept) tail_d = push_data;
        else        cnt_d  = 2'd1;
      end
    endcase

    case (state_q)
      IDLE: if (start && !hold) begin
        if (len == '0) err_d = 1'b1;
        else begin
          state_d    = RUN;
          len_d      = len;
          mode_d     = mode;
          beat_cnt_d = '0;
        end
      end
      RUN: if (accept) begin
        beat_cnt_d = beat_inc;
        if (beat_inc == len_q) state_d = DRAIN;
      end
      DRAIN: if (!hold && cnt_q == 2'd0) begin
        state_d = DONE;
        done_d  = 1'b1;
        phase_d = phase_q + 1'b1;
      end
      default: if (!hold) state_d = IDLE;
    endcase

    if (kill) begin
      state_d    = IDLE;
      cnt_d      = 2'd0;
      beat_cnt_d = '0;
      phase_d    = phase_q;
      done_d     = 1'b0;
      err_d      = (state_q != IDLE);
    end

    in_ready_d  = (state_d == RUN) && !hold && (cnt_d != 2'd2);
    out_valid_d = (cnt_d != 2'd0);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      mode_q      <= '0;
      beat_cnt_q  <= '0;
      cnt_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      first_q     <= '0;
      phase_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      beat_cnt_q  <= beat_cnt_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      first_q     <= first_d;
      phase_q     <= phase_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = head_q;
  assign out_valid = out_valid_q;
  assign beat_cnt  = beat_cnt_q;
  assign phase     = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_xfer_seq_ctrl.sv
// Randomized bench for xfer_seq_ctrl: transaction-level scoreboard of expected
// output beats, plus directed timing, stall, kill, hold, reset and wrap cases.
module tb_xfer_seq_ctrl;
  localparam int DW = 23;
  localparam int BW = 5;
  localparam int PW = 3;

  logic          clock = 1'b0;
  logic          reset_n, kill, hold, start, in_valid, out_ready;
  logic [BW-1:0] len;
  logic [1:0]    mode;
  logic [DW-1:0] in_data, out_data;
  logic          in_ready, out_valid, busy, done, err;
  logic [BW-1:0] beat_cnt;
  logic [PW-1:0] phase;

  always #5 clock = ~clock;

  xfer_seq_ctrl #(.DW(DW), .BW(BW), .PW(PW)) dut (
    .clock(clock), .reset_n(reset_n), .kill(kill), .hold(hold), .start(start),
    .len(len), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .beat_cnt(beat_cnt), .phase(phase), .busy(busy),
    .done(done), .err(err)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int in_rate, out_rate, hold_rate;
  logic [DW-1:0] src [64];
  int src_n, src_idx;

  // reference model state
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] m_first, stall_data, v;
  logic [1:0]    m_mode;
  int m_len, m_acc, m_phase, done_cnt, done_edge, first_pop, last_pop;
  logic m_active, exp_err, prev_stall, in_hs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Handshakes seen here take effect on the next rising edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      m_active = 0; m_acc = 0; m_phase = 0;
      exp_err = 0; prev_stall = 0; in_hs = 0;
    end else begin
      chk("err", err, exp_err);
      if (prev_stall) begin
        chk("stable_v", out_valid, 1);
        chk("stable_d", out_data, stall_data);
      end
      if (m_active) chk("beat_cnt", beat_cnt, m_acc);
      if (done) begin
        chk("done_act", m_active, 1);
        chk("done_len", m_acc, m_len);
        chk("done_q", exp_q.size(), 0);
        m_phase++; m_active = 0; done_cnt++; done_edge = cyc;
      end
      exp_err = (kill && m_active) || (!kill && start && !hold && !m_active && len == 0);
      in_hs = in_valid && in_ready && !hold && !kill;
      if (kill) begin
        exp_q.delete();
        m_active = 0; m_acc = 0; prev_stall = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("out_cnt", exp_q.size(), 1);
          else chk("out_data", out_data, exp_q.pop_front());
          if (first_pop < 0) first_pop = cyc + 1;
          last_pop = cyc + 1;
        end
        if (in_hs) begin
          chk("acc_act", m_active, 1);
          chk("overrun", m_acc < m_len, 1);
          if (m_mode[1])      v = (m_acc == 0) ? in_data : m_first;
          else if (m_mode[0]) v = ~in_data;
          else                v = in_data;
          if (m_acc == 0) m_first = in_data;
          exp_q.push_back(v);
          m_acc++;
        end
        if (start && !hold && !m_active && len != 0) begin
          m_active = 1; m_len = int'(len); m_mode = mode; m_acc = 0;
        end
        prev_stall = out_valid && !out_ready;
        stall_data = out_data;
      end
    end
  end

  task automatic cycle();
    @(posedge clock); #1;
    if (in_hs) src_idx++;
    start = 0; kill = 0;
    if (hold_rate > 0) hold = ($urandom_range(99) < hold_rate);
    in_valid  = (src_idx < src_n) && ($urandom_range(99) < in_rate);
    in_data   = in_valid ? src[src_idx] : DW'($urandom);
    out_ready = ($urandom_range(99) < out_rate);
  endtask

  task automatic start_burst(input int l, input int m);
    src_idx = 0;
    start = 1; len = BW'(l); mode = 2'(m);
    cycle();
  endtask

  task automatic wait_burst();
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 800) begin cycle(); n++; end
    if (done_cnt == d0) chk("timeout_done", done_cnt, d0 + 1);
    n = 0;
    while (busy && n < 50) begin cycle(); n++; end
    @(negedge clock);
    chk("busy_end", busy, 0);
    chk("phase", phase, m_phase % 8);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_beat_cnt"}, beat_cnt, 0);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    int s_edge, acc_h, n;
    reset_n = 0; kill = 0; hold = 0; start = 0; len = '0; mode = '0;
    in_data = '0; in_valid = 0; out_ready = 0;
    in_rate = 100; out_rate = 100; hold_rate = 0; src_n = 0; src_idx = 0;
    done_cnt = 0; first_pop = -1; last_pop = -1; done_edge = -1;
    repeat (3) cycle();
    @(negedge clock);
    chk_zero("rst");
    reset_n = 1;
    cycle();

    // len=4 pass-through at full rate: latency and burst timing
    src[0] = 23'h1; src[1] = 23'h2; src[2] = 23'h3; src[3] = 23'h4; src_n = 4;
    first_pop = -1;
    s_edge = cyc + 1;
    start_burst(4, 0);
    wait_burst();
    chk("t1_first_pop", first_pop, s_edge + 2);
    chk("t1_last_pop", last_pop, s_edge + 5);
    chk("t1_done_edge", done_edge, s_edge + 6);
    chk("t1_beat_cnt", beat_cnt, 4);
    chk("t1_phase", phase, 1);

    // invert, then replicate-first
    src[0] = 23'h000000; src[1] = 23'h7FFFFF; src_n = 2;
    start_burst(2, 1);
    wait_burst();
    src[0] = 23'h12345; src[1] = 23'h6789A; src[2] = 23'h3CDEF; src_n = 3;
    start_burst(3, 2);
    wait_burst();

    // output stall: buffer holds exactly two beats
    for (int i = 0; i < 6; i++) src[i] = DW'($urandom);
    src_n = 6; out_rate = 0;
    start_burst(6, 0);
    repeat (6) cycle();
    @(negedge clock);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_data", out_data, src[0]);
    chk("stall_acc", m_acc, 2);
    chk("stall_beat_cnt", beat_cnt, 2);
    out_rate = 100;
    wait_burst();

    // kill after two beats, with a start on the same edge
    for (int i = 0; i < 6; i++) src[i] = DW'($urandom);
    src_n = 6; out_rate = 0;
    start_burst(6, 0);
    repeat (4) cycle();
    chk("kill_pre_acc", m_acc, 2);
    kill = 1; start = 1; len = 5'd3;
    cycle();
    @(negedge clock);
    chk("kill_out_valid", out_valid, 0);
    chk("kill_busy", busy, 0);
    chk("kill_err", err, 1);
    chk("kill_phase", phase, m_phase % 8);
    cycle();
    @(negedge clock);
    chk("kill_busy2", busy, 0);
    chk("kill_err2", err, 0);
    out_rate = 100; src_n = 0;

    // zero-length start
    start = 1; len = '0;
    cycle();
    @(negedge clock);
    chk("len0_err", err, 1);
    chk("len0_busy", busy, 0);
    cycle();
    @(negedge clock);
    chk("len0_err2", err, 0);

    // hold mid-burst: input frozen, output drains
    for (int i = 0; i < 8; i++) src[i] = DW'($urandom);
    src_n = 8;
    start_burst(8, 0);
    n = 0;
    while (m_acc < 2 && n < 20) begin cycle(); n++; end
    hold = 1;
    acc_h = m_acc;
    repeat (6) cycle();
    @(negedge clock);
    chk("hold_acc", m_acc, acc_h);
    chk("hold_beat_cnt", beat_cnt, acc_h);
    chk("hold_in_ready", in_ready, 0);
    chk("hold_out_valid", out_valid, 0);
    hold = 0;
    wait_burst();

    // reset in the middle of a burst
    for (int i = 0; i < 10; i++) src[i] = DW'($urandom);
    src_n = 10;
    start_burst(10, 1);
    n = 0;
    while (m_acc < 3 && n < 20) begin cycle(); n++; end
    reset_n = 0;
    cycle();
    @(negedge clock);
    chk_zero("midrst");
    reset_n = 1; src_n = 0;
    cycle();

    // eight single-beat bursts wrap the phase counter
    for (int i = 0; i < 8; i++) begin
      src[0] = DW'($urandom); src_n = 1;
      start_burst(1, i % 3);
      wait_burst();
      if (i == 6) chk("phase7", phase, 7);
    end
    chk("phase_wrap", phase, 0);

    // randomized bursts with random back-pressure and hold
    for (int b = 0; b < 20; b++) begin
      int l;
      l = $urandom_range(1, 31);
      for (int i = 0; i < l; i++) src[i] = DW'($urandom);
      src_n = l;
      in_rate = $urandom_range(40, 100);
      out_rate = $urandom_range(40, 100);
      hold_rate = 0; hold = 0;
      start_burst(l, $urandom_range(0, 3));
      hold_rate = 15;
      wait_burst();
      hold_rate = 0; hold = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
